// File: rtl/writeback_stage_if.sv
// writeback_stage_if: groups the signals around the writeback stage.
// This covers the memory-stage handshake, the LSU read response and the
// register-file write port.
// The slave modport is the writeback stage's view of these signals.
// The master modport is the surrounding pipeline's view of them.
interface writeback_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic             flush;
  logic             mem_valid;
  logic             mem_ready;
  logic [4:0]       mem_rd;
  logic             mem_reg_write;
  logic [1:0]       mem_wb_sel;
  logic [XLEN-1:0]  mem_alu_result;
  logic [XLEN-1:0]  mem_pc_plus4;
  logic [2:0]       mem_funct3;
  logic             lsu_rvalid;
  logic [XLEN-1:0]  lsu_rdata;
  logic             rf_reg_write;
  logic [4:0]       rf_rd;
  logic [XLEN-1:0]  rf_wd;
  logic             wb_exc;
  logic [CNT_W-1:0] instret;

  modport master (
    output flush, mem_valid, mem_rd, mem_reg_write, mem_wb_sel,
           mem_alu_result, mem_pc_plus4, mem_funct3, lsu_rvalid, lsu_rdata,
    input  mem_ready, rf_reg_write, rf_rd, rf_wd, wb_exc, instret
  );

  modport slave (
    input  flush, mem_valid, mem_rd, mem_reg_write, mem_wb_sel,
           mem_alu_result, mem_pc_plus4, mem_funct3, lsu_rvalid, lsu_rdata,
    output mem_ready, rf_reg_write, rf_rd, rf_wd, wb_exc, instret
  );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: final RV32I pipeline stage in front of the register file.
// It selects the ALU result, the load data or PC+4, and waits for the LSU
// response on loads.
// Load data is aligned and extended before it is written.
// Every write reaches the register file as a registered one-cycle pulse.
// Optional feature: define WB_RETIRE_CNT_EN to build the instret retire
// counter. Without it, instret is tied to zero.
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic clk,
  input  logic rst_n,
  writeback_stage_if.slave bus
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t r_state, w_state_nxt;

  // Load context held while waiting for the LSU.
  logic [4:0]      r_ld_rd;
  logic            r_ld_rw;
  logic [2:0]      r_ld_f3;
  logic [1:0]      r_ld_alo;

  // Registered register-file outputs.
  logic            r_rf_we;
  logic [4:0]      r_rf_rd;
  logic [XLEN-1:0] r_rf_wd;
  logic            r_exc;

  logic            w_accept;
  logic            w_capture;
  logic            w_we;
  logic            w_exc;
  logic            w_retire;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_wd;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_err;

  assign bus.mem_ready = (r_state == IDLE);
  assign w_accept      = bus.mem_valid & bus.mem_ready & ~bus.flush;
  assign w_capture     = w_accept & (bus.mem_wb_sel == 2'b01);

  // Select the byte/half from the raw word, then extend by funct3; flag bad loads.
  always_comb begin
    w_ld_data = '0;
    w_ld_err  = 1'b0;
    case (r_ld_alo)
      2'd0:    w_byte = bus.lsu_rdata[7:0];
      2'd1:    w_byte = bus.lsu_rdata[15:8];
      2'd2:    w_byte = bus.lsu_rdata[23:16];
      default: w_byte = bus.lsu_rdata[31:24];
    endcase
    w_half = r_ld_alo[1] ? bus.lsu_rdata[31:16] : bus.lsu_rdata[15:0];
    case (r_ld_f3)
      3'b000: w_ld_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100: w_ld_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b001: begin
        w_ld_data = {{(XLEN-16){w_half[15]}}, w_half};
        w_ld_err  = r_ld_alo[0];
      end
      3'b101: begin
        w_ld_data = {{(XLEN-16){1'b0}}, w_half};
        w_ld_err  = r_ld_alo[0];
      end
      3'b010: begin
        w_ld_data = bus.lsu_rdata;
        w_ld_err  = (r_ld_alo != 2'b00);
      end
      default: w_ld_err = 1'b1;
    endcase
  end

  // Next state and next-cycle write/exception/retire decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_exc       = 1'b0;
    w_retire    = 1'b0;
    w_rd        = bus.mem_rd;
    w_wd        = bus.mem_alu_result;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (bus.mem_wb_sel)
            2'b00: begin
              w_we     = bus.mem_reg_write & (bus.mem_rd != 5'd0);
              w_retire = 1'b1;
            end
            2'b10: begin
              w_wd     = bus.mem_pc_plus4;
              w_we     = bus.mem_reg_write & (bus.mem_rd != 5'd0);
              w_retire = 1'b1;
            end
            // Reserved select: retires without touching the register file.
            2'b11:   w_retire    = 1'b1;
            default: w_state_nxt = WAIT_LOAD;
          endcase
        end
      end
      WAIT_LOAD: begin
        w_rd = r_ld_rd;
        w_wd = w_ld_data;
        // Flush beats a coincident response; the load is dropped.
        if (bus.flush) begin
          w_state_nxt = IDLE;
        end else if (bus.lsu_rvalid) begin
          w_state_nxt = IDLE;
          if (w_ld_err) begin
            w_exc = 1'b1;
          end else begin
            w_we     = r_ld_rw & (r_ld_rd != 5'd0);
            w_retire = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Capture load context on acceptance of a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_rd  <= '0;
      r_ld_rw  <= 1'b0;
      r_ld_f3  <= '0;
      r_ld_alo <= '0;
    end else if (w_capture) begin
      r_ld_rd  <= bus.mem_rd;
      r_ld_rw  <= bus.mem_reg_write;
      r_ld_f3  <= bus.mem_funct3;
      r_ld_alo <= bus.mem_alu_result[1:0];
    end
  end

  // Register the write port. Address and data hold their last value between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we <= 1'b0;
      r_rf_rd <= '0;
      r_rf_wd <= '0;
      r_exc   <= 1'b0;
    end else begin
      r_rf_we <= w_we;
      r_exc   <= w_exc;
      if (w_we) begin
        r_rf_rd <= w_rd;
        r_rf_wd <= w_wd;
      end
    end
  end

  assign bus.rf_reg_write = r_rf_we;
  assign bus.rf_rd        = r_rf_rd;
  assign bus.rf_wd        = r_rf_wd;
  assign bus.wb_exc       = r_exc;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_instret;

  // Retire counter, updated on the same edge that registers the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign bus.instret = r_instret;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
  assign bus.instret     = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed bench for writeback_stage.
// Expected writes, exceptions and retirements are queued with the cycle in
// which they must appear. Outputs are sampled on the falling edge.
module tb_writeback_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic [63:0] exp_instret = '0;

  typedef struct {
    int          due;
    bit          we;
    bit          exc;
    bit          ret;
    logic [4:0]  rd;
    logic [31:0] wd;
  } exp_t;

  exp_t q[$];

  writeback_stage_if #(.XLEN(32), .CNT_W(64)) wb_if ();

  writeback_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wb_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit we, input bit exc, input bit ret,
                      input logic [4:0] rd, input logic [31:0] wd);
    exp_t e;
    e.due = cyc + 1;
    e.we  = we;
    e.exc = exc;
    e.ret = ret;
    e.rd  = rd;
    e.wd  = wd;
    q.push_back(e);
  endtask

  // Advance one rising edge, then compare the registered outputs at the falling edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    e.due = 0; e.we = 0; e.exc = 0; e.ret = 0; e.rd = '0; e.wd = '0;
    if (q.size() > 0 && q[0].due == cyc) e = q.pop_front();
    chk("rf_reg_write", {63'd0, wb_if.rf_reg_write}, {63'd0, e.we});
    if (e.we) begin
      chk("rf_rd", {59'd0, wb_if.rf_rd}, {59'd0, e.rd});
      chk("rf_wd", {32'd0, wb_if.rf_wd}, {32'd0, e.wd});
    end
    chk("wb_exc", {63'd0, wb_if.wb_exc}, {63'd0, e.exc});
    if (e.ret) exp_instret++;
`ifdef WB_RETIRE_CNT_EN
    chk("instret", wb_if.instret, exp_instret);
`else
    chk("instret", wb_if.instret, 64'd0);
`endif
  endtask

  task automatic offer(input logic [1:0] sel, input logic [4:0] rd, input logic rw,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3);
    wb_if.mem_valid      = 1'b1;
    wb_if.mem_wb_sel     = sel;
    wb_if.mem_rd         = rd;
    wb_if.mem_reg_write  = rw;
    wb_if.mem_alu_result = alu;
    wb_if.mem_pc_plus4   = pc;
    wb_if.mem_funct3     = f3;
  endtask

  task automatic idle();
    wb_if.mem_valid = 1'b0;
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    chk(tag, {63'd0, wb_if.mem_ready}, {63'd0, exp});
  endtask

  // Load to rd=7; the response arrives three cycles after acceptance.
  task automatic load_case(input logic [2:0] f3, input logic [1:0] alo,
                           input logic [31:0] rdata, input logic [31:0] exp_wd, input bit bad);
    offer(2'b01, 5'd7, 1'b1, {30'h0000_0400, alo}, 32'h0, f3);
    chk_ready("ld_ready_accept", 1'b1);
    step();
    idle();
    chk_ready("ld_ready_wait1", 1'b0);
    step();
    chk_ready("ld_ready_wait2", 1'b0);
    step();
    chk_ready("ld_ready_wait3", 1'b0);
    wb_if.lsu_rvalid = 1'b1;
    wb_if.lsu_rdata  = rdata;
    if (bad) push(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    else     push(1'b1, 1'b0, 1'b1, 5'd7, exp_wd);
    step();
    wb_if.lsu_rvalid = 1'b0;
    chk_ready("ld_ready_after", 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    wb_if.flush = 1'b0;
    wb_if.lsu_rvalid = 1'b0;
    wb_if.lsu_rdata = '0;
    offer(2'b00, 5'd0, 1'b0, 32'h0, 32'h0, 3'b000);
    idle();
    #3;
    chk("rst_rf_reg_write", {63'd0, wb_if.rf_reg_write}, 64'd0);
    chk("rst_rf_rd", {59'd0, wb_if.rf_rd}, 64'd0);
    chk("rst_rf_wd", {32'd0, wb_if.rf_wd}, 64'd0);
    chk("rst_wb_exc", {63'd0, wb_if.wb_exc}, 64'd0);
    chk("rst_instret", wb_if.instret, 64'd0);
    chk_ready("rst_ready", 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU write, latency 1, single pulse.
    offer(2'b00, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 3'b000);
    push(1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
    step();
    idle();
    step();

    // Three back-to-back PC+4 writes.
    for (int i = 1; i <= 3; i++) begin
      offer(2'b10, 5'(i), 1'b1, 32'hDEAD_BEEF, 32'h100 + 32'(4 * i), 3'b000);
      chk_ready("b2b_ready", 1'b1);
      push(1'b1, 1'b0, 1'b1, 5'(i), 32'h100 + 32'(4 * i));
      step();
    end
    idle();
    step();

    // Load formatting and error cases.
    load_case(3'b000, 2'd2, 32'h1280_5678, 32'hFFFF_FF80, 1'b0);
    load_case(3'b100, 2'd2, 32'h1280_5678, 32'h0000_0080, 1'b0);
    load_case(3'b000, 2'd0, 32'h1280_5678, 32'h0000_0078, 1'b0);
    load_case(3'b001, 2'd2, 32'h8001_1234, 32'hFFFF_8001, 1'b0);
    load_case(3'b101, 2'd2, 32'h8001_1234, 32'h0000_8001, 1'b0);
    load_case(3'b001, 2'd0, 32'h8001_1234, 32'h0000_1234, 1'b0);
    load_case(3'b010, 2'd0, 32'h8001_1234, 32'h8001_1234, 1'b0);
    load_case(3'b001, 2'd1, 32'h8001_1234, 32'h0, 1'b1);
    load_case(3'b010, 2'd2, 32'h8001_1234, 32'h0, 1'b1);
    load_case(3'b011, 2'd0, 32'h8001_1234, 32'h0, 1'b1);
    load_case(3'b110, 2'd0, 32'h8001_1234, 32'h0, 1'b1);

    // rd=0, reserved select and reg_write=0 all retire without writing.
    offer(2'b00, 5'd0, 1'b1, 32'h55, 32'h0, 3'b000);
    push(1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
    step();
    offer(2'b11, 5'd4, 1'b1, 32'h66, 32'h0, 3'b000);
    push(1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
    step();
    offer(2'b00, 5'd6, 1'b0, 32'h77, 32'h0, 3'b000);
    push(1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
    step();

    // Flush blocks a same-cycle accept.
    offer(2'b00, 5'd9, 1'b1, 32'h99, 32'h0, 3'b000);
    wb_if.flush = 1'b1;
    step();
    wb_if.flush = 1'b0;
    idle();
    step();

    // A response while idle is ignored.
    wb_if.lsu_rvalid = 1'b1;
    step();
    wb_if.lsu_rvalid = 1'b0;

    // Flush in WAIT_LOAD, then a late response, then a normal ALU op.
    offer(2'b01, 5'd8, 1'b1, 32'h400, 32'h0, 3'b010);
    step();
    idle();
    wb_if.flush = 1'b1;
    step();
    wb_if.flush = 1'b0;
    chk_ready("flush_ready", 1'b1);
    wb_if.lsu_rvalid = 1'b1;
    wb_if.lsu_rdata  = 32'hCAFE_F00D;
    step();
    wb_if.lsu_rvalid = 1'b0;
    offer(2'b00, 5'd10, 1'b1, 32'h0000_0ABC, 32'h0, 3'b000);
    push(1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_0ABC);
    step();
    idle();
    step();

    // Flush coincident with the response wins.
    offer(2'b01, 5'd8, 1'b1, 32'h400, 32'h0, 3'b010);
    step();
    idle();
    step();
    wb_if.flush = 1'b1;
    wb_if.lsu_rvalid = 1'b1;
    step();
    wb_if.flush = 1'b0;
    wb_if.lsu_rvalid = 1'b0;
    chk_ready("flush_rv_ready", 1'b1);
    step();

    // Reset in the middle of a load clears everything at once.
    offer(2'b00, 5'd12, 1'b1, 32'h0000_0099, 32'h0, 3'b000);
    push(1'b1, 1'b0, 1'b1, 5'd12, 32'h0000_0099);
    step();
    offer(2'b01, 5'd13, 1'b1, 32'h400, 32'h0, 3'b010);
    step();
    idle();
    chk_ready("pre_rst_ready", 1'b0);
    rst_n = 1'b0;
    #1;
    exp_instret = '0;
    chk("mid_rst_rf_reg_write", {63'd0, wb_if.rf_reg_write}, 64'd0);
    chk("mid_rst_rf_rd", {59'd0, wb_if.rf_rd}, 64'd0);
    chk("mid_rst_rf_wd", {32'd0, wb_if.rf_wd}, 64'd0);
    chk("mid_rst_wb_exc", {63'd0, wb_if.wb_exc}, 64'd0);
    chk("mid_rst_instret", wb_if.instret, 64'd0);
    chk_ready("mid_rst_ready", 1'b1);
    step();
    rst_n = 1'b1;
    wb_if.lsu_rvalid = 1'b1;
    wb_if.lsu_rdata  = 32'h1111_2222;
    step();
    wb_if.lsu_rvalid = 1'b0;
    chk_ready("post_rst_ready", 1'b1);
    offer(2'b10, 5'd14, 1'b1, 32'h0, 32'h0000_2004, 3'b000);
    push(1'b1, 1'b0, 1'b1, 5'd14, 32'h0000_2004);
    step();
    idle();
    step();

    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
